// File: rtl/triumph_pkg.sv
// rtl/triumph_pkg.sv - shared load-size codes and writeback entry record
package triumph_pkg;

  localparam int XLEN_MAX  = 64;
  localparam int RADDR_MAX = 8;

  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;
  localparam logic [1:0] LD_D = 2'd3;

  // Sized for the widest build; narrower builds zero-extend into it.
  typedef struct packed {
    logic                 valid;
    logic [RADDR_MAX-1:0] rd;
    logic [XLEN_MAX-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/triumph_ld_align.sv
// rtl/triumph_ld_align.sv - combinational load lane select and sign/zero extension
module triumph_ld_align
  import triumph_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  rdata_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  output logic [XLEN-1:0]  result_o
);

  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] keep_mask;
  int unsigned     nbits;

  always_comb begin
    lane      = rdata_i >> {off_i, 3'b000};
    nbits     = XLEN;
    keep_mask = '1;
    result_o  = lane;
    case (size_i)
      LD_B:    nbits = 8;
      LD_H:    nbits = 16;
      LD_W:    nbits = 32;
      default: nbits = XLEN;
    endcase
    // Full-width loads (and dword on a 32-bit datapath) pass straight through.
    if (nbits < XLEN) begin
      keep_mask = ~({XLEN{1'b1}} << nbits);
      result_o  = (lane & keep_mask) |
                  ((lane[nbits-1] && !unsigned_i) ? ~keep_mask : '0);
    end
  end

endmodule

// File: rtl/triumph_wb_pipe.sv
// rtl/triumph_wb_pipe.sv - valid/ready writeback stage with 2-entry skid buffer,
// load formatting, x0 suppression, flush, forwarding view and retire counter
module triumph_wb_pipe
  import triumph_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int RADDR_W = 5,
  parameter  int CNT_W   = 32,
  localparam int OFF_W   = $clog2(XLEN/8)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ex_valid_i,
  output logic               ex_ready_o,
  input  logic [RADDR_W-1:0] ex_rd_addr_i,
  input  logic [XLEN-1:0]    ex_wdata_i,
  input  logic               ex_is_load_i,
  input  logic [1:0]         ex_ld_size_i,
  input  logic               ex_ld_unsigned_i,
  input  logic [OFF_W-1:0]   ex_byte_off_i,
  input  logic [XLEN-1:0]    dcache_rdata_i,
  input  logic               flush_i,
  output logic               rf_we_o,
  output logic [RADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]    rf_wdata_o,
  input  logic               rf_ready_i,
  output logic               fwd_valid_o,
  output logic [RADDR_W-1:0] fwd_addr_o,
  output logic [XLEN-1:0]    fwd_data_o,
  output logic [CNT_W-1:0]   retire_cnt_o
);

  wb_entry_t        head_q, head_d, skid_q, skid_d, incoming;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  ld_data;
  logic             capture, drain;

  triumph_ld_align #(.XLEN(XLEN)) u_ld_align (
    .rdata_i    (dcache_rdata_i),
    .off_i      (ex_byte_off_i),
    .size_i     (ex_ld_size_i),
    .unsigned_i (ex_ld_unsigned_i),
    .result_o   (ld_data)
  );

  always_comb begin
    incoming       = '0;
    incoming.valid = 1'b1;
    incoming.rd    = RADDR_MAX'(ex_rd_addr_i);
    incoming.data  = XLEN_MAX'(ex_is_load_i ? ld_data : ex_wdata_i);
  end

  assign capture = ex_valid_i && ready_q && !flush_i;
  // An x0 entry drains without waiting for the register file.
  assign drain   = head_q.valid && (head_q.rd == '0 || rf_ready_i) && !flush_i;

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = '0;
      skid_d = '0;
    end else if (drain) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (skid_q.valid) begin
        head_d = skid_q;
        skid_d = capture ? incoming : '0;
      end else begin
        head_d = capture ? incoming : '0;
      end
    end else if (capture) begin
      if (!head_q.valid) head_d = incoming;
      else               skid_d = incoming;
    end
    ready_d = !skid_d.valid;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      head_q  <= head_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_ready_o   = ready_q;
  assign rf_we_o      = head_q.valid && head_q.rd != '0 && !flush_i && !rst_i;
  assign rf_waddr_o   = head_q.valid ? head_q.rd[RADDR_W-1:0] : '0;
  assign rf_wdata_o   = head_q.valid ? head_q.data[XLEN-1:0] : '0;
  assign fwd_valid_o  = rf_we_o;
  assign fwd_addr_o   = rf_waddr_o;
  assign fwd_data_o   = rf_wdata_o;
  assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_triumph_wb_pipe.sv
// tb/tb_triumph_wb_pipe.sv - directed table-driven bench for triumph_wb_pipe
module tb_triumph_wb_pipe;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_ready, ex_is_load, ex_uns, flush, rf_ready;
  logic [4:0]  ex_rd, rf_waddr, fwd_addr;
  logic [31:0] ex_wdata, dc_rdata, rf_wdata, fwd_data;
  logic [1:0]  ex_size, ex_off;
  logic        rf_we, fwd_valid;
  logic [3:0]  cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  triumph_wb_pipe #(.XLEN(32), .RADDR_W(5), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_rd_addr_i(ex_rd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
    .ex_ld_size_i(ex_size), .ex_ld_unsigned_i(ex_uns), .ex_byte_off_i(ex_off),
    .dcache_rdata_i(dc_rdata), .flush_i(flush), .rf_we_o(rf_we),
    .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_ready_i(rf_ready),
    .fwd_valid_o(fwd_valid), .fwd_addr_o(fwd_addr), .fwd_data_o(fwd_data),
    .retire_cnt_o(cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rf(input string name, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({name, ".we"}, rf_we, we);
    chk({name, ".addr"}, rf_waddr, a);
    chk({name, ".data"}, rf_wdata, d);
    chk({name, ".fwd_valid"}, fwd_valid, we);
    chk({name, ".fwd_addr"}, fwd_addr, a);
    chk({name, ".fwd_data"}, fwd_data, d);
  endtask

  task automatic put(input logic [4:0] rd, input logic [31:0] d);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = rd; ex_wdata = d;
  endtask

  typedef struct {
    logic        is_load;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];
  logic seen_we;

  initial begin
    vecs[0] = '{1, 2'd0, 0, 2'd1, 5'd1,  32'h0,        1, 32'hFFFFFFF6};
    vecs[1] = '{1, 2'd1, 1, 2'd2, 5'd2,  32'h0,        1, 32'h00001234};
    vecs[2] = '{1, 2'd2, 0, 2'd0, 5'd3,  32'h0,        1, 32'h1234F678};
    vecs[3] = '{1, 2'd0, 1, 2'd0, 5'd4,  32'h0,        1, 32'h00000078};
    vecs[4] = '{1, 2'd1, 0, 2'd0, 5'd5,  32'h0,        1, 32'hFFFFF678};
    vecs[5] = '{1, 2'd0, 0, 2'd3, 5'd6,  32'h0,        1, 32'h00000012};
    vecs[6] = '{1, 2'd3, 0, 2'd0, 5'd7,  32'h0,        1, 32'h1234F678};
    vecs[7] = '{1, 2'd1, 0, 2'd1, 5'd8,  32'h0,        1, 32'h000034F6};
    vecs[8] = '{0, 2'd0, 0, 2'd0, 5'd31, 32'hCAFEBABE, 1, 32'hCAFEBABE};
    vecs[9] = '{0, 2'd0, 0, 2'd0, 5'd0,  32'hDEADBEEF, 0, 32'hDEADBEEF};

    rst = 1'b1; ex_valid = 0; ex_rd = 0; ex_wdata = 0; ex_is_load = 0;
    ex_size = 0; ex_uns = 0; ex_off = 0; dc_rdata = 32'h1234F678;
    flush = 0; rf_ready = 1;

    tick(); tick();
    chk_rf("reset", 0, 0, 0);
    chk("reset.ready", ex_ready, 0);
    chk("reset.cnt", cnt, 0);
    rst = 1'b0;
    tick();
    chk("reset.ready_rise", ex_ready, 1);

    // Back-to-back vectors at full throughput.
    for (int i = 0; i < 10; i++) begin
      ex_valid = 1; ex_is_load = vecs[i].is_load; ex_size = vecs[i].size;
      ex_uns = vecs[i].uns; ex_off = vecs[i].off; ex_rd = vecs[i].rd;
      ex_wdata = vecs[i].wdata;
      tick();
      chk_rf($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].rd, vecs[i].exp_data);
      chk($sformatf("vec%0d.ready", i), ex_ready, 1);
    end
    ex_valid = 0; ex_is_load = 0;
    tick();
    chk_rf("vec_drained", 0, 0, 0);
    chk("vec.cnt", cnt, 10);

    // Backpressure: A, B accepted, C held.
    rf_ready = 0;
    put(1, 32'hA); tick();
    chk_rf("bp.A_head", 1, 1, 32'hA);
    chk("bp.ready_after_A", ex_ready, 1);
    put(2, 32'hB); tick();
    chk("bp.ready_after_B", ex_ready, 0);
    put(3, 32'hC); tick();
    chk_rf("bp.C_held", 1, 1, 32'hA);
    chk("bp.ready_held", ex_ready, 0);
    rf_ready = 1; tick();
    chk_rf("bp.B", 1, 2, 32'hB);
    chk("bp.ready_recover", ex_ready, 1);
    tick();
    ex_valid = 0;
    chk_rf("bp.C", 1, 3, 32'hC);
    tick();
    chk_rf("bp.empty", 0, 0, 0);
    chk("bp.cnt", cnt, 13);

    // x0 entry drains without rf_ready.
    rf_ready = 0;
    put(0, 32'hDEADBEEF); tick();
    ex_valid = 0;
    chk_rf("x0.head", 0, 0, 32'hDEADBEEF);
    tick();
    chk_rf("x0.drained", 0, 0, 0);
    chk("x0.cnt", cnt, 14);

    // Flush with HEAD and SKID full and a same-cycle EX entry.
    put(1, 32'h11); tick();
    put(2, 32'h22); tick();
    chk("fl.ready_full", ex_ready, 0);
    put(4, 32'h44); flush = 1; rf_ready = 1;
    #1;
    chk("fl.we_in_flush", rf_we, 0);
    tick();
    flush = 0; ex_valid = 0;
    chk_rf("fl.after", 0, 0, 0);
    chk("fl.ready", ex_ready, 1);
    chk("fl.cnt", cnt, 14);
    put(9, 32'h99); tick();
    ex_valid = 0;
    chk_rf("fl.next", 1, 9, 32'h99);
    tick();
    chk("fl.next_cnt", cnt, 15);

    // Counter wrap: 17 retirements from reset.
    rst = 1; tick(); rst = 0; tick();
    chk("wrap.cnt0", cnt, 0);
    for (int i = 0; i < 17; i++) begin
      put(5'(i + 1), 32'(i)); tick();
    end
    ex_valid = 0; tick();
    chk("wrap.cnt", cnt, 1);

    // Reset mid-stream with rf stalled.
    rf_ready = 0;
    put(1, 32'h1); tick();
    put(2, 32'h2); tick();
    put(3, 32'h3); rst = 1;
    #1;
    chk("rst.we_during", rf_we, 0);
    tick(); tick();
    chk_rf("rst.outputs", 0, 0, 0);
    chk("rst.cnt", cnt, 0);
    chk("rst.ready", ex_ready, 0);
    rst = 0; ex_valid = 0; rf_ready = 1;
    seen_we = 0;
    tick();
    chk("rst.ready_rise", ex_ready, 1);
    for (int i = 0; i < 3; i++) begin
      seen_we |= rf_we;
      tick();
    end
    chk("rst.no_writes", seen_we, 0);
    chk("rst.cnt_after", cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
